// File: rtl/veririsc_pkg.sv
// Shared VeriRISC types and bus widths used by the controller, loader, arbiter and memory model.
package veririsc_pkg;

  localparam int MEM_AWIDTH = 5;
  localparam int MEM_DWIDTH = 8;

  typedef enum logic [1:0] {
    ARB_CPU,
    ARB_LD,
    ARB_LOCK
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_LD
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU controller and the loader/debug port:
// CPU priority, starvation relief for the loader, and a bounded exclusive loader lock.
module mem_arbiter
  import veririsc_pkg::*;
#(
  parameter int AWIDTH     = MEM_AWIDTH,
  parameter int DWIDTH     = MEM_DWIDTH,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              ld_req,
  input  logic              ld_wr,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DWIDTH-1:0] rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              cpu_stall
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

  arb_state_e        state, state_nx;
  logic [SW-1:0]     starve_cnt, starve_nx;
  logic [LW-1:0]     lock_cnt, lock_nx;
  logic              lock_block, lock_block_nx;
  logic              lock_eff;
  owner_e            rd_owner, rd_owner_nx;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cpu_gnt       = 1'b0;
    ld_gnt        = 1'b0;
    state_nx      = state;
    starve_nx     = starve_cnt;
    lock_nx       = lock_cnt;
    lock_block_nx = lock_block;
    lock_eff      = ld_lock & ~lock_block;

    // Grants are forced low while reset is asserted, independent of the clock.
    if (reset_n) begin
      case (state)
        ARB_CPU: begin
          cpu_gnt = cpu_req;
          ld_gnt  = ld_req & ~cpu_req;
        end
        ARB_LD: begin
          ld_gnt  = ld_req;
          cpu_gnt = cpu_req & ~ld_req;
        end
        ARB_LOCK: ld_gnt = ld_req;
        default: ;
      endcase
    end

    if (state != ARB_LOCK) begin
      if (ld_gnt) starve_nx = '0;
      else if (ld_req && starve_cnt != STARVE_TOP) starve_nx = starve_cnt + SW'(1);
    end

    if (!ld_lock) lock_block_nx = 1'b0;

    case (state)
      ARB_CPU: begin
        if (ld_gnt && lock_eff) begin
          state_nx = ARB_LOCK;
          lock_nx  = LW'(1);
        end else if (ld_req && !ld_gnt && starve_nx == STARVE_TOP) begin
          state_nx = ARB_LD;
        end
      end
      ARB_LD: begin
        if (ld_gnt && lock_eff) begin
          state_nx = ARB_LOCK;
          lock_nx  = LW'(1);
        end else if (ld_gnt || !ld_req) begin
          state_nx = ARB_CPU;
        end
      end
      ARB_LOCK: begin
        if (!ld_lock) begin
          state_nx = ARB_CPU;
          lock_nx  = '0;
        end else if (lock_cnt == LOCK_TOP) begin
          // Forced release: the loader must drop ld_lock before it can lock again.
          state_nx      = ARB_CPU;
          lock_nx       = '0;
          lock_block_nx = 1'b1;
        end else begin
          lock_nx = lock_cnt + LW'(1);
        end
      end
      default: state_nx = ARB_CPU;
    endcase
  end

  always_comb begin
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    rd_owner_nx = OWN_NONE;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_rd    = ~cpu_wr;
      mem_wr    = cpu_wr;
      if (!cpu_wr) rd_owner_nx = OWN_CPU;
    end else if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_rd    = ~ld_wr;
      mem_wr    = ld_wr;
      if (!ld_wr) rd_owner_nx = OWN_LD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_CPU;
      starve_cnt <= '0;
      lock_cnt   <= '0;
      lock_block <= 1'b0;
      rd_owner   <= OWN_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      lock_cnt   <= lock_nx;
      lock_block <= lock_block_nx;
      rd_owner   <= rd_owner_nx;
      addr_q     <= mem_addr;
      wdata_q    <= mem_wdata;
    end
  end

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign ld_rvalid  = (rd_owner == OWN_LD);
  assign rdata      = (rd_owner != OWN_NONE) ? mem_rdata : '0;
  assign cpu_stall  = cpu_req & ~cpu_gnt;

endmodule
